// File: rtl/fft_pingpong_ram.sv
// fft_pingpong_ram
//   Double-buffered complex-sample memory for the FFT datapath. Two banks of
//   2**N words, each word {real, img} of 2*BIT_WIDTH bits. The compute ports
//   (A/B) own bank[bank_sel]; the I/O port owns bank[~bank_sel]. A swap
//   handshake exchanges ownership, and a clear sequencer zeroes the I/O bank.
//
// Ports
//   clk, reset            clock, synchronous active-low reset
//   we_a/b, add_a/b       compute port write enables and addresses
//   real/img_din_a/b      compute port write data
//   dout_a/b              registered compute read data {real, img}
//   io_we, io_add, io_din I/O port write enable, address, data
//   io_dout               registered I/O read data
//   swap_req / swap_ack   bank swap request (level) / one-cycle acknowledge
//   clr_req / clr_busy    clear start pulse / clear in progress
//   bank_sel              bank owned by the compute ports
//   frame_cnt             completed swaps, wrapping
module fft_pingpong_ram #(
    parameter int BIT_WIDTH = 16,
    parameter int N         = 9,
    parameter int FRAME_W   = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   we_a,
    input  logic                   we_b,
    input  logic [N-1:0]           add_a,
    input  logic [N-1:0]           add_b,
    input  logic [BIT_WIDTH-1:0]   real_din_a,
    input  logic [BIT_WIDTH-1:0]   img_din_a,
    input  logic [BIT_WIDTH-1:0]   real_din_b,
    input  logic [BIT_WIDTH-1:0]   img_din_b,
    output logic [2*BIT_WIDTH-1:0] dout_a,
    output logic [2*BIT_WIDTH-1:0] dout_b,
    input  logic                   io_we,
    input  logic [N-1:0]           io_add,
    input  logic [2*BIT_WIDTH-1:0] io_din,
    output logic [2*BIT_WIDTH-1:0] io_dout,
    input  logic                   swap_req,
    output logic                   swap_ack,
    input  logic                   clr_req,
    output logic                   clr_busy,
    output logic                   bank_sel,
    output logic [FRAME_W-1:0]     frame_cnt
);

    localparam int DEPTH = 2 ** N;
    localparam int DW    = 2 * BIT_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SWAP  = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [N-1:0]   clr_cnt;
    logic           io_bank;
    logic           clr_wr;

    logic [DW-1:0]  mem [2][DEPTH];

    // Next state and state-decoded outputs
    always_comb begin
        state_nxt = state;
        clr_busy  = 1'b0;
        swap_ack  = 1'b0;
        case (state)
            IDLE: begin
                // clear wins over swap; a held swap_req is served afterwards
                if (clr_req)       state_nxt = CLEAR;
                else if (swap_req) state_nxt = SWAP;
            end
            CLEAR: begin
                clr_busy = 1'b1;
                if (clr_cnt == '1) state_nxt = IDLE;
            end
            SWAP: begin
                swap_ack  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            clr_cnt   <= '0;
            bank_sel  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && clr_req)
                clr_cnt <= '0;
            else if (state == CLEAR)
                clr_cnt <= clr_cnt + N'(1);
            if (state == SWAP) begin
                bank_sel  <= ~bank_sel;
                frame_cnt <= frame_cnt + FRAME_W'(1);
            end
        end
    end

    always_comb begin
        io_bank = ~bank_sel;
        // a reset edge aborts the clear without writing the current address
        clr_wr  = (state == CLEAR) && reset;
    end

    // Storage: B is written before A so A wins on a shared address.
    // Non-blocking writes give read-first behaviour on every port.
    always_ff @(posedge clk) begin
        if (we_b) mem[bank_sel][add_b] <= {real_din_b, img_din_b};
        if (we_a) mem[bank_sel][add_a] <= {real_din_a, img_din_a};
        if (clr_wr)
            mem[io_bank][clr_cnt] <= '0;
        else if (io_we)
            mem[io_bank][io_add] <= io_din;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            dout_a  <= '0;
            dout_b  <= '0;
            io_dout <= '0;
        end else begin
            dout_a  <= mem[bank_sel][add_a];
            dout_b  <= mem[bank_sel][add_b];
            io_dout <= mem[io_bank][io_add];
        end
    end

endmodule

// File: tb/tb_fft_pingpong_ram.sv
// tb_fft_pingpong_ram
//   Self-checking bench for fft_pingpong_ram. A behavioural memory model
//   (two plain arrays plus the expected bank mapping and frame count) predicts
//   every read; scenario tasks drive stimulus and compare inline.
module tb_fft_pingpong_ram;

    localparam int BW    = 16;
    localparam int N     = 9;
    localparam int FW    = 8;
    localparam int DEPTH = 512;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic            we_a, we_b, io_we, swap_req, clr_req;
    logic [N-1:0]    add_a, add_b, io_add;
    logic [BW-1:0]   real_din_a, img_din_a, real_din_b, img_din_b;
    logic [2*BW-1:0] io_din, dout_a, dout_b, io_dout;
    logic            swap_ack, clr_busy, bank_sel;
    logic [FW-1:0]   frame_cnt;

    fft_pingpong_ram #(.BIT_WIDTH(BW), .N(N), .FRAME_W(FW)) dut (
        .clk(clk), .reset(reset),
        .we_a(we_a), .we_b(we_b), .add_a(add_a), .add_b(add_b),
        .real_din_a(real_din_a), .img_din_a(img_din_a),
        .real_din_b(real_din_b), .img_din_b(img_din_b),
        .dout_a(dout_a), .dout_b(dout_b),
        .io_we(io_we), .io_add(io_add), .io_din(io_din), .io_dout(io_dout),
        .swap_req(swap_req), .swap_ack(swap_ack),
        .clr_req(clr_req), .clr_busy(clr_busy),
        .bank_sel(bank_sel), .frame_cnt(frame_cnt)
    );

    int total = 0;
    int bad   = 0;

    // reference model
    logic [31:0]   mem_m [2][DEPTH];
    logic          msel;
    logic [FW-1:0] mframe;
    logic          mdrop;
    logic [31:0]   exp_a, exp_b, exp_io;

    // One clock: reads see memory before this edge's writes; A beats B.
    task automatic tick();
        exp_a  = mem_m[msel][add_a];
        exp_b  = mem_m[msel][add_b];
        exp_io = mem_m[~msel][io_add];
        if (we_b) mem_m[msel][add_b] = {real_din_b, img_din_b};
        if (we_a) mem_m[msel][add_a] = {real_din_a, img_din_a};
        if (io_we && !mdrop) mem_m[~msel][io_add] = io_din;
        @(posedge clk);
        #1;
    endtask

    task automatic fill_io_bank();
        for (int i = 0; i < DEPTH; i++) begin
            io_we  = 1'b1;
            io_add = i[N-1:0];
            io_din = $urandom | 32'h1;
            tick();
        end
        io_we = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        total += 7;
        if (dout_a    !== '0)   begin bad++; $display("FAIL reset_dout_a: got %h want 0", dout_a); end
        if (dout_b    !== '0)   begin bad++; $display("FAIL reset_dout_b: got %h want 0", dout_b); end
        if (io_dout   !== '0)   begin bad++; $display("FAIL reset_io_dout: got %h want 0", io_dout); end
        if (swap_ack  !== 1'b0) begin bad++; $display("FAIL reset_swap_ack: got %b want 0", swap_ack); end
        if (clr_busy  !== 1'b0) begin bad++; $display("FAIL reset_clr_busy: got %b want 0", clr_busy); end
        if (bank_sel  !== 1'b0) begin bad++; $display("FAIL reset_bank_sel: got %b want 0", bank_sel); end
        if (frame_cnt !== '0)   begin bad++; $display("FAIL reset_frame_cnt: got %h want 0", frame_cnt); end
        reset  = 1'b1;
        msel   = 1'b0;
        mframe = '0;
    endtask

    task automatic test_io_basic();
        we_a = 1'b1; add_a = 9'd5; {real_din_a, img_din_a} = 32'hDEAD0005;
        io_we = 1'b1; io_add = 9'd5; io_din = 32'h00010002;
        tick();
        we_a = 1'b0; io_we = 1'b0;
        tick();
        total += 2;
        if (io_dout !== 32'h00010002) begin bad++; $display("FAIL io_read: got %h want 00010002", io_dout); end
        if (dout_a  !== 32'hDEAD0005) begin bad++; $display("FAIL bank_isolation: got %h want dead0005", dout_a); end
    endtask

    task automatic test_compute_ports();
        we_a = 1'b1; add_a = 9'd3; real_din_a = 16'h1234; img_din_a = 16'h5678;
        we_b = 1'b1; add_b = 9'd7; real_din_b = 16'hAAAA; img_din_b = 16'h5555;
        tick();
        we_a = 1'b0; we_b = 1'b0;
        tick();
        total += 2;
        if (dout_a !== 32'h12345678) begin bad++; $display("FAIL ab_write_a: got %h want 12345678", dout_a); end
        if (dout_b !== 32'hAAAA5555) begin bad++; $display("FAIL ab_write_b: got %h want aaaa5555", dout_b); end

        // same-address collision
        we_a = 1'b1; add_a = 9'd9; real_din_a = 16'h1111; img_din_a = 16'h2222;
        we_b = 1'b1; add_b = 9'd9; real_din_b = 16'h3333; img_din_b = 16'h4444;
        tick();
        we_a = 1'b0; we_b = 1'b0;
        tick();
        total += 2;
        if (dout_a !== 32'h11112222) begin bad++; $display("FAIL collide_a: got %h want 11112222", dout_a); end
        if (dout_b !== 32'h11112222) begin bad++; $display("FAIL collide_b: got %h want 11112222", dout_b); end

        // read-first on A, and cross-port old data on B
        we_a = 1'b1; add_a = 9'd3; real_din_a = 16'hFFFF; img_din_a = 16'h0000;
        add_b = 9'd3;
        tick();
        we_a = 1'b0;
        total += 2;
        if (dout_a !== 32'h12345678) begin bad++; $display("FAIL read_first_old: got %h want 12345678", dout_a); end
        if (dout_b !== 32'h12345678) begin bad++; $display("FAIL cross_port_old: got %h want 12345678", dout_b); end
        tick();
        total += 1;
        if (dout_a !== 32'hFFFF0000) begin bad++; $display("FAIL read_first_new: got %h want ffff0000", dout_a); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            we_a = 1'b1; add_a = i[N-1:0]; {real_din_a, img_din_a} = $urandom;
            io_we = 1'b1; io_add = i[N-1:0]; io_din = $urandom;
            tick();
        end
        for (int c = 0; c < 300; c++) begin
            we_a  = 1'($urandom_range(1)); add_a = 9'($urandom_range(15));
            we_b  = 1'($urandom_range(1)); add_b = 9'($urandom_range(15));
            io_we = 1'($urandom_range(1)); io_add = 9'($urandom_range(15));
            {real_din_a, img_din_a} = $urandom;
            {real_din_b, img_din_b} = $urandom;
            io_din = $urandom;
            tick();
            total += 3;
            if (dout_a  !== exp_a)  begin bad++; $display("FAIL rand_a c=%0d: got %h want %h", c, dout_a, exp_a); end
            if (dout_b  !== exp_b)  begin bad++; $display("FAIL rand_b c=%0d: got %h want %h", c, dout_b, exp_b); end
            if (io_dout !== exp_io) begin bad++; $display("FAIL rand_io c=%0d: got %h want %h", c, io_dout, exp_io); end
        end
        we_a = 1'b0; we_b = 1'b0; io_we = 1'b0;
    endtask

    task automatic test_swap();
        for (int i = 0; i < 16; i++) begin
            io_we = 1'b1; io_add = i[N-1:0]; io_din = $urandom;
            tick();
        end
        io_we = 1'b0;
        swap_req = 1'b1;
        tick();
        total += 2;
        if (swap_ack !== 1'b1) begin bad++; $display("FAIL swap_ack_pulse: got %b want 1", swap_ack); end
        if (bank_sel !== 1'b0) begin bad++; $display("FAIL swap_sel_hold: got %b want 0", bank_sel); end
        swap_req = 1'b0;
        tick();
        msel = ~msel; mframe = mframe + 1'b1;
        total += 3;
        if (swap_ack  !== 1'b0)   begin bad++; $display("FAIL swap_ack_end: got %b want 0", swap_ack); end
        if (bank_sel  !== msel)   begin bad++; $display("FAIL swap_sel: got %b want %b", bank_sel, msel); end
        if (frame_cnt !== mframe) begin bad++; $display("FAIL swap_frame: got %0d want %0d", frame_cnt, mframe); end
        for (int i = 0; i < 16; i++) begin
            add_a = i[N-1:0];
            tick();
            total += 1;
            if (dout_a !== exp_a) begin bad++; $display("FAIL swap_read a=%0d: got %h want %h", i, dout_a, exp_a); end
        end

        // back-to-back: request held across the IDLE cycle gives a second ack
        swap_req = 1'b1;
        tick();
        total += 1;
        if (swap_ack !== 1'b1) begin bad++; $display("FAIL b2b_ack1: got %b want 1", swap_ack); end
        tick();
        msel = ~msel; mframe = mframe + 1'b1;
        total += 1;
        if (swap_ack !== 1'b0) begin bad++; $display("FAIL b2b_gap: got %b want 0", swap_ack); end
        tick();
        total += 1;
        if (swap_ack !== 1'b1) begin bad++; $display("FAIL b2b_ack2: got %b want 1", swap_ack); end
        swap_req = 1'b0;
        tick();
        msel = ~msel; mframe = mframe + 1'b1;
        total += 3;
        if (swap_ack  !== 1'b0)   begin bad++; $display("FAIL b2b_end: got %b want 0", swap_ack); end
        if (bank_sel  !== msel)   begin bad++; $display("FAIL b2b_sel: got %b want %b", bank_sel, msel); end
        if (frame_cnt !== mframe) begin bad++; $display("FAIL b2b_frame: got %0d want %0d", frame_cnt, mframe); end
    endtask

    task automatic test_clear_deferred_swap();
        int busy_cycles;
        fill_io_bank();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        total += 1;
        if (clr_busy !== 1'b1) begin bad++; $display("FAIL clr_start: got %b want 1", clr_busy); end
        busy_cycles = 1;
        swap_req = 1'b1;
        mdrop = 1'b1;
        for (int k = 0; k < 600 && clr_busy; k++) begin
            io_we = 1'b1; io_add = 9'($urandom); io_din = $urandom | 32'h1;
            tick();
            if (clr_busy) busy_cycles++;
            total += 1;
            if (swap_ack !== 1'b0) begin bad++; $display("FAIL swap_mid_clear k=%0d: got %b want 0", k, swap_ack); end
        end
        io_we = 1'b0;
        mdrop = 1'b0;
        total += 1;
        if (busy_cycles != DEPTH) begin bad++; $display("FAIL clr_len: got %0d want %0d", busy_cycles, DEPTH); end
        for (int i = 0; i < DEPTH; i++) mem_m[~msel][i] = '0;
        tick();
        total += 1;
        if (swap_ack !== 1'b1) begin bad++; $display("FAIL deferred_ack: got %b want 1", swap_ack); end
        swap_req = 1'b0;
        tick();
        msel = ~msel; mframe = mframe + 1'b1;
        total += 2;
        if (bank_sel  !== msel)   begin bad++; $display("FAIL deferred_sel: got %b want %b", bank_sel, msel); end
        if (frame_cnt !== mframe) begin bad++; $display("FAIL deferred_frame: got %0d want %0d", frame_cnt, mframe); end
        for (int i = 0; i < DEPTH; i++) begin
            add_a = i[N-1:0];
            tick();
            total += 1;
            if (dout_a !== 32'h0) begin bad++; $display("FAIL cleared a=%0d: got %h want 0", i, dout_a); end
        end
    endtask

    task automatic test_clear_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        msel = 1'b0; mframe = '0;
        fill_io_bank();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (100) tick();
        for (int i = 0; i < 100; i++) mem_m[~msel][i] = '0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        total += 3;
        if (clr_busy  !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", clr_busy); end
        if (bank_sel  !== 1'b0) begin bad++; $display("FAIL abort_sel: got %b want 0", bank_sel); end
        if (frame_cnt !== '0)   begin bad++; $display("FAIL abort_frame: got %0d want 0", frame_cnt); end
        for (int i = 0; i < DEPTH; i++) begin
            io_add = i[N-1:0];
            tick();
            total += 1;
            if (io_dout !== exp_io) begin bad++; $display("FAIL abort_data a=%0d: got %h want %h", i, io_dout, exp_io); end
        end
    endtask

    task automatic test_frame_wrap();
        for (int s = 0; s < 257; s++) begin
            swap_req = 1'b1;
            tick();
            swap_req = 1'b0;
            total += 1;
            if (swap_ack !== 1'b1) begin bad++; $display("FAIL wrap_ack s=%0d: got %b want 1", s, swap_ack); end
            tick();
            msel = ~msel; mframe = mframe + 1'b1;
            total += 1;
            if (frame_cnt !== mframe) begin bad++; $display("FAIL wrap_frame s=%0d: got %0d want %0d", s, frame_cnt, mframe); end
        end
        total += 1;
        if (bank_sel !== msel) begin bad++; $display("FAIL wrap_sel: got %b want %b", bank_sel, msel); end
    endtask

    initial begin
        reset = 1'b0; we_a = 1'b0; we_b = 1'b0; io_we = 1'b0;
        swap_req = 1'b0; clr_req = 1'b0;
        add_a = '0; add_b = '0; io_add = '0; io_din = '0;
        real_din_a = '0; img_din_a = '0; real_din_b = '0; img_din_b = '0;
        msel = 1'b0; mframe = '0; mdrop = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            mem_m[0][i] = '0;
            mem_m[1][i] = '0;
        end
        @(posedge clk);
        #1;
        test_reset();
        test_io_basic();
        test_compute_ports();
        test_random();
        test_swap();
        test_clear_deferred_swap();
        test_clear_reset();
        test_frame_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
